// File: rtl/ehl_ddr_phy_gate_train.sv
// Multi-lane DDR PHY read-gate training: sweeps gate delay, keeps each lane's first passing window.
// Optional macro EHL_DDR_GATE_TRAIN_CENTER_EN selects window centre instead of window start.
module ehl_ddr_phy_gate_train #(
  parameter int unsigned NUM_LANES = 2,
  parameter int unsigned DELAY_W   = 4,
  parameter int unsigned SAMPLES   = 4,
  parameter int unsigned WAIT_CYC  = 8
) (
  input  logic                           ref_clk,
  input  logic                           reset_n,
  input  logic                           start,
  output logic                           busy,
  output logic                           done,
  output logic [NUM_LANES-1:0]           error,
  output logic                           rd_req,
  input  logic                           rd_ack,
  output logic                           dfi_rdlvl_gate_en,
  input  logic [NUM_LANES-1:0]           dfi_rdlvl_resp,
  output logic [NUM_LANES*DELAY_W-1:0]   dfi_rdlvl_gate_delay
);

  localparam int unsigned LEN_W  = DELAY_W + 1;
  localparam int unsigned WAIT_W = 8;
  localparam int unsigned SAMP_W = (SAMPLES > 1) ? $clog2(SAMPLES) + 1 : 1;

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_SET    = 3'd1;
  localparam logic [2:0] S_REQ    = 3'd2;
  localparam logic [2:0] S_WAIT   = 3'd3;
  localparam logic [2:0] S_SAMPLE = 3'd4;
  localparam logic [2:0] S_NEXT   = 3'd5;
  localparam logic [2:0] S_CALC   = 3'd6;
  localparam logic [2:0] S_DONE   = 3'd7;

  logic [2:0]                            r_state;
  logic [2:0]                            w_state_nxt;
  logic [DELAY_W-1:0]                    r_d;
  logic [DELAY_W-1:0]                    w_d_inc;
  logic                                  w_d_last;
  logic [WAIT_W-1:0]                     r_wcnt;
  logic                                  w_wait_last;
  logic [SAMP_W-1:0]                     r_samp;
  logic                                  w_samp_last;
  logic [NUM_LANES-1:0]                  r_acc;
  logic [NUM_LANES-1:0]                  r_found;
  logic [NUM_LANES-1:0]                  r_open;
  logic [NUM_LANES-1:0][DELAY_W-1:0]     r_wstart;
  logic [NUM_LANES-1:0][LEN_W-1:0]       r_wlen;
  logic [NUM_LANES-1:0][DELAY_W-1:0]     w_final;
  logic [NUM_LANES-1:0][DELAY_W-1:0]     r_delay;
  logic [NUM_LANES-1:0]                  r_error;
  logic                                  r_busy;
  logic                                  r_done;
  logic                                  r_rd_req;
  logic                                  r_gate_en;

  assign w_d_inc     = r_d + DELAY_W'(1);
  assign w_d_last    = &r_d;
  assign w_wait_last = (r_wcnt == WAIT_W'(WAIT_CYC - 1));
  assign w_samp_last = (r_samp == SAMP_W'(SAMPLES - 1));

  // State register
  always_ff @(posedge ref_clk) begin
    if (!reset_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state logic
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:   if (start) w_state_nxt = S_SET;
      S_SET:    w_state_nxt = S_REQ;
      S_REQ:    if (rd_ack) w_state_nxt = S_WAIT;
      S_WAIT:   if (w_wait_last) w_state_nxt = S_SAMPLE;
      S_SAMPLE: w_state_nxt = w_samp_last ? S_NEXT : S_REQ;
      S_NEXT:   w_state_nxt = w_d_last ? S_CALC : S_SET;
      S_CALC:   w_state_nxt = S_DONE;
      S_DONE:   w_state_nxt = S_IDLE;
      default:  w_state_nxt = S_IDLE;
    endcase
  end

  // Control outputs registered from the next state so they align with the state they describe
  always_ff @(posedge ref_clk) begin
    if (!reset_n) begin
      r_busy    <= 1'b0;
      r_done    <= 1'b0;
      r_rd_req  <= 1'b0;
      r_gate_en <= 1'b0;
    end else begin
      r_busy    <= (w_state_nxt != S_IDLE) && (w_state_nxt != S_DONE);
      r_done    <= (w_state_nxt == S_DONE);
      r_rd_req  <= (w_state_nxt == S_REQ);
      r_gate_en <= (w_state_nxt != S_IDLE) && (w_state_nxt != S_DONE);
    end
  end

  // Final per-lane delay from the first passing window
  always_comb begin
    w_final = '0;
    for (int unsigned i = 0; i < NUM_LANES; i++) begin
      if (r_found[i]) begin
`ifdef EHL_DDR_GATE_TRAIN_CENTER_EN
        w_final[i] = r_wstart[i] + DELAY_W'((r_wlen[i] - LEN_W'(1)) >> 1);
`else
        w_final[i] = r_wstart[i];
`endif
      end
    end
  end

  always_ff @(posedge ref_clk) begin
    if (!reset_n) begin
      r_d      <= '0;
      r_wcnt   <= '0;
      r_samp   <= '0;
      r_acc    <= '1;
      r_found  <= '0;
      r_open   <= '0;
      r_wstart <= '0;
      r_wlen   <= '0;
      r_delay  <= '0;
      r_error  <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_d      <= '0;
            r_samp   <= '0;
            r_acc    <= '1;
            r_found  <= '0;
            r_open   <= '0;
            r_wstart <= '0;
            r_wlen   <= '0;
            r_delay  <= '0;
            r_error  <= '0;
          end
        end
        S_REQ: begin
          r_wcnt <= '0;
        end
        S_WAIT: begin
          r_wcnt <= r_wcnt + WAIT_W'(1);
        end
        S_SAMPLE: begin
          r_acc  <= r_acc & dfi_rdlvl_resp;
          r_samp <= w_samp_last ? '0 : r_samp + SAMP_W'(1);
        end
        S_NEXT: begin
          // Only the first window is tracked; once closed, later passes are ignored
          for (int unsigned i = 0; i < NUM_LANES; i++) begin
            if (r_acc[i]) begin
              if (!r_found[i]) begin
                r_found[i]  <= 1'b1;
                r_open[i]   <= 1'b1;
                r_wstart[i] <= r_d;
                r_wlen[i]   <= LEN_W'(1);
              end else if (r_open[i]) begin
                r_wlen[i] <= r_wlen[i] + LEN_W'(1);
              end
            end else begin
              r_open[i] <= 1'b0;
            end
          end
          r_acc <= '1;
          if (!w_d_last) begin
            r_d     <= w_d_inc;
            r_delay <= {NUM_LANES{w_d_inc}};
          end
        end
        S_CALC: begin
          r_delay <= w_final;
          r_error <= ~r_found;
        end
        default: begin
        end
      endcase
    end
  end

  assign busy                 = r_busy;
  assign done                 = r_done;
  assign error                = r_error;
  assign rd_req               = r_rd_req;
  assign dfi_rdlvl_gate_en    = r_gate_en;
  assign dfi_rdlvl_gate_delay = r_delay;

endmodule

// File: tb/tb_ehl_ddr_phy_gate_train.sv
// Randomized bench for ehl_ddr_phy_gate_train; a controller/lane model answers reads and a
// window-search reference model predicts final delays and error bits.
module tb_ehl_ddr_phy_gate_train;

  localparam int unsigned NL = 2;
  localparam int unsigned DW = 4;
  localparam int unsigned NS = 4;
  localparam int unsigned WC = 8;
  localparam int ND = 1 << DW;

  logic            ref_clk = 1'b0;
  logic            reset_n = 1'b0;
  logic            start   = 1'b0;
  logic            rd_ack  = 1'b0;
  logic            busy;
  logic            done;
  logic            rd_req;
  logic            gate_en;
  logic [NL-1:0]   error;
  logic [NL-1:0]   resp = '0;
  logic [NL*DW-1:0] gdel;

  int checks   = 0;
  int failures = 0;

  bit pass_map [NL][ND];
  bit fault_en = 0;
  int fault_l = 0, fault_d = 0, fault_s = 0;
  int ack_cnt = 0;
  int stall = 0;
  int stall_first = 0;
  bit ack_req = 0;

  ehl_ddr_phy_gate_train #(
    .NUM_LANES(NL), .DELAY_W(DW), .SAMPLES(NS), .WAIT_CYC(WC)
  ) dut (
    .ref_clk              (ref_clk),
    .reset_n              (reset_n),
    .start                (start),
    .busy                 (busy),
    .done                 (done),
    .error                (error),
    .rd_req               (rd_req),
    .rd_ack               (rd_ack),
    .dfi_rdlvl_gate_en    (gate_en),
    .dfi_rdlvl_resp       (resp),
    .dfi_rdlvl_gate_delay (gdel)
  );

  always #5 ref_clk = ~ref_clk;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Lane response for one training read
  function automatic bit resp_bit(int l, int d, int s);
    return pass_map[l][d] && !(fault_en && l == fault_l && d == fault_d && s == fault_s);
  endfunction

  // A delay setting passes only if every sample at it was good
  function automatic bit good(int l, int d);
    return pass_map[l][d] && !(fault_en && l == fault_l && d == fault_d);
  endfunction

  function automatic int first_pass(int l);
    for (int d = 0; d < ND; d++) if (good(l, d)) return d;
    return -1;
  endfunction

  function automatic int win_len(int l, int ws);
    int n = 0;
    while (ws + n < ND && good(l, ws + n)) n++;
    return n;
  endfunction

  function automatic logic [DW-1:0] exp_delay(int l);
    int ws = first_pass(l);
    if (ws < 0) return '0;
`ifdef EHL_DDR_GATE_TRAIN_CENTER_EN
    return DW'(ws + (win_len(l, ws) - 1) / 2);
`else
    return DW'(ws);
`endif
  endfunction

  function automatic logic [NL-1:0] exp_err();
    logic [NL-1:0] v = '0;
    for (int l = 0; l < NL; l++) v[l] = (first_pass(l) < 0);
    return v;
  endfunction

  // Controller and byte-lane model: acks reads after a random stall, answers from the pass map
  initial begin
    forever begin
      @(negedge ref_clk);
      if (rd_ack) begin
        if (ack_req) begin
          ack_cnt++;
          stall = $urandom_range(0, 3);
        end
        rd_ack = 1'b0;
      end else if (rd_req) begin
        if (stall == 0) begin
          check_eq("delay_at_read", 64'(gdel), 64'({NL{DW'(ack_cnt / NS)}}));
          rd_ack  = 1'b1;
          ack_req = 1'b1;
        end else begin
          stall--;
        end
      end else if ($urandom_range(0, 7) == 0) begin
        rd_ack  = 1'b1;
        ack_req = 1'b0;
      end
      if (!busy) begin
        ack_cnt = 0;
        stall   = stall_first;
      end
      if (ack_cnt > 0) begin
        for (int l = 0; l < NL; l++)
          resp[l] = resp_bit(l, (ack_cnt - 1) / NS, (ack_cnt - 1) % NS);
      end else begin
        resp = NL'($urandom);
      end
    end
  end

  task automatic clear_maps();
    for (int l = 0; l < NL; l++)
      for (int d = 0; d < ND; d++) pass_map[l][d] = 0;
    fault_en = 0;
  endtask

  task automatic set_win(int l, int lo, int hi);
    for (int d = lo; d <= hi; d++) if (d < ND) pass_map[l][d] = 1;
  endtask

  task automatic rand_lane(int l);
    int m, ws, len, ws2;
    for (int d = 0; d < ND; d++) pass_map[l][d] = 0;
    m = $urandom_range(0, 4);
    if (m != 0) begin
      ws  = $urandom_range(0, ND - 1);
      len = $urandom_range(1, ND - ws);
      set_win(l, ws, ws + len - 1);
      ws2 = ws + len + 1 + $urandom_range(0, 3);
      if (m >= 3 && ws2 < ND) set_win(l, ws2, ws2 + $urandom_range(0, 3));
    end
  endtask

  task automatic kick(input string name);
    @(negedge ref_clk);
    start = 1'b1;
    @(negedge ref_clk);
    start = 1'b0;
    check_eq({name, "_busy_rise"}, 64'(busy), 64'(1));
    check_eq({name, "_gate_en"}, 64'(gate_en), 64'(1));
  endtask

  task automatic finish(input string name, input bit start_busy, input bit start_done);
    int cyc = 0;
    while (!done && cyc < 4000) begin
      start = (start_busy && cyc == 100);
      @(negedge ref_clk);
      cyc++;
    end
    start = 1'b0;
    if (!done) begin
      check_eq({name, "_timeout"}, 64'(0), 64'(1));
      return;
    end
    check_eq({name, "_busy_at_done"}, 64'(busy), 64'(0));
    check_eq({name, "_gate_en_at_done"}, 64'(gate_en), 64'(0));
    for (int l = 0; l < NL; l++)
      check_eq($sformatf("%s_lane%0d", name, l), 64'(gdel[l*DW +: DW]), 64'(exp_delay(l)));
    check_eq({name, "_error"}, 64'(error), 64'(exp_err()));
    if (start_done) start = 1'b1;
    @(negedge ref_clk);
    start = 1'b0;
    check_eq({name, "_done_pulse"}, 64'(done), 64'(0));
    check_eq({name, "_idle_after"}, 64'(busy), 64'(0));
    check_eq({name, "_hold_error"}, 64'(error), 64'(exp_err()));
  endtask

  initial begin
    int cyc;
    int ndone;
    clear_maps();
    repeat (3) @(negedge ref_clk);
    check_eq("rst_busy", 64'(busy), 64'(0));
    check_eq("rst_done", 64'(done), 64'(0));
    check_eq("rst_error", 64'(error), 64'(0));
    check_eq("rst_rd_req", 64'(rd_req), 64'(0));
    check_eq("rst_gate_en", 64'(gate_en), 64'(0));
    check_eq("rst_delay", 64'(gdel), 64'(0));
    reset_n = 1'b1;

    clear_maps(); set_win(0, 3, 8); set_win(1, 5, 5);
    kick("basic"); finish("basic", 1'b0, 1'b1);

    clear_maps(); set_win(0, 4, 11);
    kick("nolane1"); finish("nolane1", 1'b1, 1'b0);

    clear_maps(); set_win(0, 2, 3); set_win(0, 10, 12); set_win(1, 0, 15);
    kick("twowin"); finish("twowin", 1'b0, 1'b0);

    clear_maps(); set_win(0, 3, 8); set_win(1, 7, 9);
    fault_en = 1; fault_l = 0; fault_d = 6; fault_s = $urandom_range(0, NS - 1);
    kick("fault"); finish("fault", 1'b0, 1'b0);

    clear_maps(); set_win(0, 1, 2); set_win(1, 14, 15);
    stall_first = 20;
    repeat (2) @(negedge ref_clk);
    kick("stall");
    for (int i = 0; i < 20; i++) begin
      @(negedge ref_clk);
      check_eq($sformatf("stall_req_%0d", i), 64'({rd_req, gdel}), 64'({1'b1, {(NL*DW){1'b0}}}));
    end
    stall_first = 0;
    finish("stall", 1'b0, 1'b0);

    clear_maps(); set_win(0, 3, 8); set_win(1, 5, 5);
    kick("rstmid");
    cyc = 0;
    while (gdel[DW-1:0] != DW'(7) && cyc < 2000) begin
      @(negedge ref_clk);
      cyc++;
    end
    check_eq("rstmid_reach_d7", 64'(gdel[DW-1:0]), 64'(7));
    reset_n = 1'b0;
    @(negedge ref_clk);
    reset_n = 1'b1;
    check_eq("rstmid_outs", 64'({busy, done, rd_req, gate_en, error, gdel}), 64'(0));
    ndone = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge ref_clk);
      if (done || busy) ndone++;
    end
    check_eq("rstmid_no_done", 64'(ndone), 64'(0));
    kick("resweep"); finish("resweep", 1'b0, 1'b0);

    for (int r = 0; r < 6; r++) begin
      clear_maps();
      for (int l = 0; l < NL; l++) rand_lane(l);
      if ($urandom_range(0, 2) == 0) begin
        fault_en = 1;
        fault_l  = $urandom_range(0, NL - 1);
        fault_d  = $urandom_range(0, ND - 1);
        fault_s  = $urandom_range(0, NS - 1);
      end
      stall_first = $urandom_range(0, 3);
      repeat (2) @(negedge ref_clk);
      kick($sformatf("rnd%0d", r));
      finish($sformatf("rnd%0d", r), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
